// File: rtl/st_pkg.sv
// -----------------------------------------------------------------------------
// st_pkg
// Types and defaults shared by the space-time pulse-width temporal primitives.
//   gamma_state_e : per-gamma-cycle decoder state (WAIT, MEAS, DONE)
//   result_t      : decoded result {value, inf, err}
//   *_DEF         : default gamma cycle length and legal pulse width
// -----------------------------------------------------------------------------
package st_pkg;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;

    // Widest gamma count any user of result_t may carry. A gamma cycle of up to
    // 2**16 clocks fits; narrower users zero-extend into the field.
    localparam int TW_MAX = 16;

    typedef enum logic [1:0] {
        WAIT = 2'd0,   // no rising edge seen yet in this gamma cycle
        MEAS = 2'd1,   // first pulse still high, width being counted
        DONE = 2'd2    // first pulse finished, watching for extra edges
    } gamma_state_e;

    typedef struct packed {
        logic [TW_MAX-1:0] value;   // gamma count of the first rising edge
        logic              inf;     // no rising edge in the gamma cycle
        logic              err;     // bad width or more than one rising edge
    } result_t;

endpackage

// File: rtl/gamma_counter.sv
// -----------------------------------------------------------------------------
// gamma_counter
// Free-running gamma-cycle counter: counts 0..GAMMA_CYCLE_WIDTH-1 and wraps.
// Ports:
//   aclk  : clock
//   grst  : asynchronous active-high reset (count returns to 0)
//   count : current gamma count
//   last  : high while count = GAMMA_CYCLE_WIDTH-1 (final clock of the cycle)
// -----------------------------------------------------------------------------
module gamma_counter
    import st_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    output logic [TW-1:0] count,
    output logic          last
);

    logic [TW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == TW'(GAMMA_CYCLE_WIDTH - 1));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign last  = w_last;

endmodule

// File: rtl/pulse_decoder.sv
// -----------------------------------------------------------------------------
// pulse_decoder
// Receiver endpoint for the pulse-width temporal code. Each gamma cycle it
// records the gamma count of the first rising edge on x, checks that the pulse
// is exactly PULSE_WIDTH clocks wide and that no second edge follows, and
// offers the result over a valid/ready handshake at the end of the cycle.
// Ports:
//   aclk, grst : clock, asynchronous active-high reset
//   x          : pulse-coded input line, synchronous to aclk
//   out_valid  : result held and valid
//   out_ready  : consumer accepts when out_valid & out_ready at posedge
//   out_value  : arrival time of the first rising edge (0 when out_inf)
//   out_inf    : no rising edge in the gamma cycle
//   out_err    : wrong pulse width or more than one rising edge
//   overrun    : sticky, a result was dropped while out_valid was pending
//   gamma_cnt  : current gamma count
// -----------------------------------------------------------------------------
module pulse_decoder
    import st_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter  int PULSE_WIDTH       = PULSE_WIDTH_DEF,
    localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_value,
    output logic          out_inf,
    output logic          out_err,
    output logic          overrun,
    output logic [TW-1:0] gamma_cnt
);

    // Width counter saturates one above the legal width, which is enough to
    // tell "too long" apart from "exactly right".
    localparam int            WW      = $clog2(PULSE_WIDTH + 2);
    localparam logic [WW-1:0] W_SAT   = WW'(PULSE_WIDTH + 1);
    localparam logic [WW-1:0] W_LEGAL = WW'(PULSE_WIDTH);

    logic [TW-1:0] w_gcnt;
    logic          w_last;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH)
    ) u_gamma_counter (
        .aclk  (aclk),
        .grst  (grst),
        .count (w_gcnt),
        .last  (w_last)
    );

    // ------------------------------------------------------------------
    // Edge detection and per-gamma measurement state
    // ------------------------------------------------------------------
    logic          r_x_q;
    gamma_state_e  r_state;
    logic [TW-1:0] r_t;
    logic [WW-1:0] r_width;
    logic          r_err;

    logic          w_rise;
    gamma_state_e  w_state_upd, w_state_nxt;
    logic [TW-1:0] w_t_upd, w_t_nxt;
    logic [WW-1:0] w_width_upd, w_width_nxt;
    logic          w_err_upd, w_err_nxt;
    result_t       w_result;

    assign w_rise = x & ~r_x_q;

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            // Previous sample resets high: a line already high when reset is
            // released is the tail of an old pulse, not a new spike.
            r_x_q   <= 1'b1;
            r_state <= WAIT;
            r_t     <= '0;
            r_width <= '0;
            r_err   <= 1'b0;
        end else begin
            r_x_q   <= x;
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_width <= w_width_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The result must include the sample taken on the last clock of the gamma
    // cycle, so it is formed from the post-update values (w_*_upd) and the
    // measurement state is cleared only afterwards.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_upd = r_state;
        w_t_upd     = r_t;
        w_width_upd = r_width;
        w_err_upd   = r_err;

        unique case (r_state)
            WAIT: begin
                if (w_rise) begin
                    w_t_upd     = w_gcnt;
                    w_width_upd = WW'(1);
                    w_state_upd = MEAS;
                end
            end
            MEAS: begin
                if (x) begin
                    if (r_width != W_SAT) begin
                        w_width_upd = r_width + 1'b1;
                    end
                end else begin
                    w_state_upd = DONE;
                end
            end
            DONE: begin
                if (w_rise) begin
                    w_err_upd = 1'b1;
                end
            end
            default: begin
                w_state_upd = WAIT;
            end
        endcase

        w_result       = '0;
        w_result.inf   = (w_state_upd == WAIT);
        w_result.value = w_result.inf ? '0 : TW_MAX'(w_t_upd);
        w_result.err   = w_err_upd | (~w_result.inf & (w_width_upd != W_LEGAL));

        w_state_nxt = w_state_upd;
        w_t_nxt     = w_t_upd;
        w_width_nxt = w_width_upd;
        w_err_nxt   = w_err_upd;
        if (w_last) begin
            w_state_nxt = WAIT;
            w_t_nxt     = '0;
            w_width_nxt = '0;
            w_err_nxt   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    logic          r_out_valid;
    logic [TW-1:0] r_out_value;
    logic          r_out_inf;
    logic          r_out_err;
    logic          r_overrun;
    logic          w_load;

    // A new result may replace the held one when nothing is pending or the
    // pending one is being accepted on this very edge.
    assign w_load = w_last & (~r_out_valid | out_ready);

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_out_inf   <= 1'b0;
            r_out_err   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_value <= TW'(w_result.value);
                r_out_inf   <= w_result.inf;
                r_out_err   <= w_result.err;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_last & ~w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign out_inf   = r_out_inf;
    assign out_err   = r_out_err;
    assign overrun   = r_overrun;
    assign gamma_cnt = w_gcnt;

endmodule

// File: tb/tb_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_pulse_decoder
// Self-checking bench for pulse_decoder (G=16, P=8). A behavioural model keeps
// each gamma cycle's samples as a bit vector and derives the result from it at
// gamma end; a compare process checks every output on every falling edge, and
// directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_pulse_decoder;

    localparam int G  = 16;
    localparam int P  = 8;
    localparam int TW = $clog2(G);

    logic          aclk = 1'b0;
    logic          grst;
    logic          x;
    logic          out_ready;
    logic          out_valid;
    logic [TW-1:0] out_value;
    logic          out_inf;
    logic          out_err;
    logic          overrun;
    logic [TW-1:0] gamma_cnt;

    always #5 aclk = ~aclk;

    pulse_decoder #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (P)
    ) dut (
        .aclk      (aclk),
        .grst      (grst),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_inf   (out_inf),
        .out_err   (out_err),
        .overrun   (overrun),
        .gamma_cnt (gamma_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        int value;
        bit inf;
        bit err;
    } exp_t;

    // Result of one gamma cycle from its samples s[0..G-1] and the sample
    // that preceded s[0].
    function automatic exp_t eval(input logic [G-1:0] s, input logic prev);
        exp_t r;
        int   edges = 0;
        int   t     = -1;
        int   w     = 0;
        logic p     = prev;
        for (int k = 0; k < G; k++) begin
            if (s[k] && !p) begin
                edges++;
                if (t < 0) t = k;
            end
            p = s[k];
        end
        if (t < 0) begin
            r.value = 0;
            r.inf   = 1'b1;
            r.err   = 1'b0;
        end else begin
            for (int k = t; k < G; k++) begin
                if (!s[k]) break;
                w++;
            end
            r.value = t;
            r.inf   = 1'b0;
            r.err   = (edges > 1) || (w != P);
        end
        return r;
    endfunction

    function automatic logic [G-1:0] with_sample(input logic [G-1:0] s, input int k, input logic v);
        s[k] = v;
        return s;
    endfunction

    function automatic logic [G-1:0] pulse(input int t, input int w);
        logic [G-1:0] s = '0;
        for (int k = 0; k < G; k++) begin
            if (k >= t && k < t + w) s[k] = 1'b1;
        end
        return s;
    endfunction

    int           m_g;
    logic         m_xprev;
    logic         m_prev0;
    logic [G-1:0] m_s;
    logic         m_valid;
    logic         m_ovr;
    exp_t         m_res;

    always @(posedge aclk or posedge grst) begin
        if (grst) begin
            m_g     <= 0;
            m_xprev <= 1'b1;
            m_prev0 <= 1'b1;
            m_s     <= '0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_res   <= '{0, 1'b0, 1'b0};
        end else begin
            m_xprev  <= x;
            m_s[m_g] <= x;
            if (m_g == 0) m_prev0 <= m_xprev;
            if (m_g == G - 1) begin
                if (!m_valid || out_ready) begin
                    m_valid <= 1'b1;
                    m_res   <= eval(with_sample(m_s, m_g, x), m_prev0);
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            m_g <= (m_g == G - 1) ? 0 : m_g + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge aclk) begin
        if (!grst) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_value", 32'(out_value), m_res.value);
            check("out_inf",   32'(out_inf),   32'(m_res.inf));
            check("out_err",   32'(out_err),   32'(m_res.err));
            check("overrun",   32'(overrun),   32'(m_ovr));
            check("gamma_cnt", 32'(gamma_cnt), m_g);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic align();
        int n = 0;
        while (m_g != 0 && n < 2 * G) begin
            @(negedge aclk);
            n++;
        end
        if (m_g != 0) check("align_timeout", 32'(m_g), 0);
    endtask

    // One gamma cycle: pat[k] is x sampled at gcnt k. rdy_mode 0/1 drives
    // out_ready low/high from gcnt 1 on (gcnt 0 keeps the previous level);
    // rdy_mode 2 randomises it every clock.
    task automatic run_bits(input logic [G-1:0] pat, input int rdy_mode);
        align();
        for (int k = 0; k < G; k++) begin
            x = pat[k];
            if (rdy_mode == 2)  out_ready = ($urandom_range(3) != 0);
            else if (k != 0)    out_ready = (rdy_mode == 1);
            @(negedge aclk);
        end
    endtask

    task automatic expect_out(input string tag, input bit v, input int val,
                              input bit inf, input bit err, input bit ovr);
        check({tag, ".valid"},   32'(out_valid), 32'(v));
        check({tag, ".value"},   32'(out_value), val);
        check({tag, ".inf"},     32'(out_inf),   32'(inf));
        check({tag, ".err"},     32'(out_err),   32'(err));
        check({tag, ".overrun"}, 32'(overrun),   32'(ovr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        grst      = 1'b1;
        x         = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge aclk);
        expect_out("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("reset.gamma_cnt", 32'(gamma_cnt), 0);
        grst = 1'b0;

        // Legal pulse at 3, 8 wide
        run_bits(16'h07F8, 1);
        expect_out("legal", 1'b1, 3, 1'b0, 1'b0, 1'b0);
        check("legal.gamma_cnt", 32'(gamma_cnt), 0);

        // No pulse
        run_bits(16'h0000, 1);
        expect_out("none", 1'b1, 0, 1'b1, 1'b0, 1'b0);

        // Short pulse at 2 (5 wide), then pulse truncated at gamma end
        run_bits(16'h007C, 1);
        expect_out("short", 1'b1, 2, 1'b0, 1'b1, 1'b0);
        run_bits(16'hF000, 1);
        expect_out("trunc", 1'b1, 12, 1'b0, 1'b1, 1'b0);

        // Two edges (1 and 11), second spills into next cycle
        run_bits(16'hF9FE, 1);
        expect_out("double", 1'b1, 1, 1'b0, 1'b1, 1'b0);
        run_bits(16'h0007, 1);
        expect_out("spill", 1'b1, 0, 1'b1, 1'b0, 1'b0);

        // Back-pressure for three gamma cycles
        run_bits(16'h07F8, 0);
        expect_out("bp1", 1'b1, 3, 1'b0, 1'b0, 1'b0);
        run_bits(16'h0000, 0);
        expect_out("bp2", 1'b1, 3, 1'b0, 1'b0, 1'b1);
        run_bits(16'h007C, 0);
        expect_out("bp3", 1'b1, 3, 1'b0, 1'b0, 1'b1);
        run_bits(16'h0000, 1);
        expect_out("bp_release", 1'b1, 0, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a pulse, line high across release
        align();
        for (int k = 0; k < 6; k++) begin
            x = (k >= 3);
            @(negedge aclk);
        end
        x    = 1'b1;
        grst = 1'b1;
        #1;
        expect_out("midrst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("midrst.gamma_cnt", 32'(gamma_cnt), 0);
        repeat (2) @(negedge aclk);
        grst = 1'b0;
        run_bits(16'h001F, 1);
        expect_out("post_rst", 1'b1, 0, 1'b1, 1'b0, 1'b0);

        // Randomised traffic
        for (int c = 0; c < 150; c++) begin
            logic [G-1:0] pat;
            int           mode;
            mode = $urandom_range(4);
            unique case (mode)
                0: pat = '0;
                1: pat = pulse($urandom_range(G - 1), P);
                2: pat = pulse($urandom_range(G - 1), $urandom_range(12, 1));
                3: pat = pulse($urandom_range(5), $urandom_range(P, 1)) |
                         pulse($urandom_range(G - 1, 8), $urandom_range(P, 1));
                default: pat = G'($urandom);
            endcase
            run_bits(pat, (c % 10 == 7) ? 0 : ((c % 3 == 0) ? 2 : 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
